// File: rtl/mprj_wb_guard.sv
// Wishbone guard between the management core's user-project bus and the user area.
// Bounds slave response time; optional status counters under MPRJ_WB_GUARD_STATUS_EN.
module mprj_wb_guard #(
    parameter int          TIMEOUT_CYCLES = 255,
    parameter logic [31:0] ERR_DATA       = 32'hDEAD_BEEF
) (
    input  logic        core_clk,
    input  logic        core_rstn,
    input  logic        mprj_wb_iena,
    input  logic        m_cyc_i,
    input  logic        m_stb_i,
    input  logic        m_we_i,
    input  logic [3:0]  m_sel_i,
    input  logic [31:0] m_adr_i,
    input  logic [31:0] m_dat_i,
    output logic        m_ack_o,
    output logic [31:0] m_dat_o,
    output logic        s_cyc_o,
    output logic        s_stb_o,
    output logic        s_we_o,
    output logic [3:0]  s_sel_o,
    output logic [31:0] s_adr_o,
    output logic [31:0] s_dat_o,
    input  logic        s_ack_i,
    input  logic [31:0] s_dat_i,
    input  logic        timeout_clr,
    output logic        timeout_flag,
    output logic [7:0]  timeout_cnt
);
    localparam int            CW   = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CW-1:0] LAST = CW'(TIMEOUT_CYCLES - 1);

    typedef enum logic [1:0] {IDLE, REQ, ACK} state_t;

    state_t        state, state_nxt;
    logic [CW-1:0] wait_cnt;
    logic          holdoff;
    logic          lat_req, dat_ld, to_evt;
    logic [31:0]   dat_nxt;

    always_comb begin
        state_nxt = state;
        lat_req   = 1'b0;
        dat_ld    = 1'b0;
        dat_nxt   = m_dat_o;
        to_evt    = 1'b0;
        case (state)
            IDLE: begin
                // holdoff keeps a still-asserted stb from re-launching right after an ack
                if (m_cyc_i && m_stb_i && !holdoff) begin
                    if (mprj_wb_iena) begin
                        lat_req   = 1'b1;
                        state_nxt = REQ;
                    end else begin
                        dat_ld    = 1'b1;
                        dat_nxt   = '0;
                        state_nxt = ACK;
                    end
                end
            end
            REQ: begin
                if (!m_cyc_i) begin
                    state_nxt = IDLE;
                end else if (s_ack_i) begin
                    dat_ld    = 1'b1;
                    dat_nxt   = s_dat_i;
                    state_nxt = ACK;
                end else if (!mprj_wb_iena) begin
                    dat_ld    = 1'b1;
                    dat_nxt   = '0;
                    state_nxt = ACK;
                end else if (wait_cnt == LAST) begin
                    dat_ld    = 1'b1;
                    dat_nxt   = ERR_DATA;
                    to_evt    = 1'b1;
                    state_nxt = ACK;
                end
            end
            ACK:     state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge core_clk or negedge core_rstn) begin
        if (!core_rstn) begin
            state    <= IDLE;
            holdoff  <= 1'b0;
            wait_cnt <= '0;
            m_dat_o  <= '0;
            s_we_o   <= 1'b0;
            s_sel_o  <= '0;
            s_adr_o  <= '0;
            s_dat_o  <= '0;
        end else begin
            state   <= state_nxt;
            holdoff <= (state == ACK);
            if (lat_req) begin
                wait_cnt <= '0;
                s_we_o   <= m_we_i;
                s_sel_o  <= m_sel_i;
                s_adr_o  <= m_adr_i;
                s_dat_o  <= m_dat_i;
            end else if (state == REQ) begin
                wait_cnt <= wait_cnt + CW'(1);
            end
            if (dat_ld) m_dat_o <= dat_nxt;
        end
    end

    // Decoded from the async-reset state so reset drops the slave immediately
    assign s_cyc_o = (state == REQ);
    assign s_stb_o = (state == REQ);
    assign m_ack_o = (state == ACK);

`ifdef MPRJ_WB_GUARD_STATUS_EN
    logic       flag_q;
    logic [7:0] cnt_q;

    always_ff @(posedge core_clk or negedge core_rstn) begin
        if (!core_rstn) begin
            flag_q <= 1'b0;
            cnt_q  <= '0;
        end else if (to_evt) begin
            flag_q <= 1'b1;
            cnt_q  <= timeout_clr ? 8'd1 : ((cnt_q == 8'hFF) ? cnt_q : cnt_q + 8'd1);
        end else if (timeout_clr) begin
            flag_q <= 1'b0;
            cnt_q  <= '0;
        end
    end

    assign timeout_flag = flag_q;
    assign timeout_cnt  = cnt_q;
`else
    logic status_unused;
    assign status_unused = timeout_clr | to_evt;
    assign timeout_flag  = 1'b0;
    assign timeout_cnt   = '0;
`endif

endmodule

// File: tb/tb_mprj_wb_guard.sv
// Self-checking bench for mprj_wb_guard: vector table, timeout/status corners,
// randomized transactions against a transaction-level model, and reset mid-request.
module tb_mprj_wb_guard;
    localparam int          T   = 8;
    localparam logic [31:0] ERR = 32'hDEAD_BEEF;
`ifdef MPRJ_WB_GUARD_STATUS_EN
    localparam bit STAT = 1'b1;
`else
    localparam bit STAT = 1'b0;
`endif

    logic        core_clk, core_rstn, mprj_wb_iena;
    logic        m_cyc_i, m_stb_i, m_we_i;
    logic [3:0]  m_sel_i;
    logic [31:0] m_adr_i, m_dat_i;
    logic        m_ack_o;
    logic [31:0] m_dat_o;
    logic        s_cyc_o, s_stb_o, s_we_o;
    logic [3:0]  s_sel_o;
    logic [31:0] s_adr_o, s_dat_o;
    logic        s_ack_i;
    logic [31:0] s_dat_i;
    logic        timeout_clr, timeout_flag;
    logic [7:0]  timeout_cnt;

    mprj_wb_guard #(.TIMEOUT_CYCLES(T), .ERR_DATA(ERR)) dut (
        .core_clk(core_clk), .core_rstn(core_rstn), .mprj_wb_iena(mprj_wb_iena),
        .m_cyc_i(m_cyc_i), .m_stb_i(m_stb_i), .m_we_i(m_we_i), .m_sel_i(m_sel_i),
        .m_adr_i(m_adr_i), .m_dat_i(m_dat_i), .m_ack_o(m_ack_o), .m_dat_o(m_dat_o),
        .s_cyc_o(s_cyc_o), .s_stb_o(s_stb_o), .s_we_o(s_we_o), .s_sel_o(s_sel_o),
        .s_adr_o(s_adr_o), .s_dat_o(s_dat_o), .s_ack_i(s_ack_i), .s_dat_i(s_dat_i),
        .timeout_clr(timeout_clr), .timeout_flag(timeout_flag), .timeout_cnt(timeout_cnt)
    );

    initial core_clk = 1'b0;
    always #5 core_clk = ~core_clk;

    typedef struct {
        logic        iena0;
        logic        we;
        logic [3:0]  sel;
        logic [31:0] adr;
        logic [31:0] dat;
        logic [31:0] rdata;
        int          lat;    // REQ cycle index on which slave acks, -1 never
        int          drop;   // REQ cycle index on which iena falls, -1 never
        int          abort;  // REQ cycle index on which cyc falls, -1 never
        int          exp_acks;
        logic [31:0] exp_rd;
        int          exp_stbs;
        logic        exp_to;
    } vec_t;

    int checks = 0;
    int failures = 0;
    int exp_cnt = 0;
    logic exp_flag = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Spec-level outcome of one request: priority abort > ack > iena drop > timeout
    task automatic model(input logic iena0, input int lat, input int drop, input int abort,
                         input logic [31:0] rdata, output int acks, output logic [31:0] rd,
                         output int stbs, output logic to);
        to = 1'b0; acks = 1; rd = '0; stbs = 0;
        if (!iena0) return;
        for (int k = 0; k < T; k++) begin
            stbs = k + 1;
            if (k == abort) begin acks = 0; return; end
            if (k == lat)   begin rd = rdata; return; end
            if (k == drop)  begin rd = '0; return; end
        end
        rd = ERR; to = 1'b1;
    endtask

    task automatic status_update(input logic to, input logic clr);
        if (to) begin
            exp_flag = 1'b1;
            exp_cnt  = clr ? 1 : ((exp_cnt == 255) ? 255 : exp_cnt + 1);
        end
    endtask

    task automatic run_txn(input logic iena0, input logic we, input logic [3:0] sel,
                           input logic [31:0] adr, input logic [31:0] dat, input logic [31:0] rdata,
                           input int lat, input int drop, input int abort, input logic clr_last,
                           output int acks, output logic [31:0] rd, output int stbs,
                           output int ack_at, output int bad);
        acks = 0; rd = '0; stbs = 0; ack_at = -1; bad = 0;
        @(negedge core_clk);
        mprj_wb_iena = iena0; m_cyc_i = 1'b1; m_stb_i = 1'b1;
        m_we_i = we; m_sel_i = sel; m_adr_i = adr; m_dat_i = dat;
        for (int c = 0; c < 20; c++) begin
            @(negedge core_clk);
            s_ack_i = 1'b0; timeout_clr = 1'b0; s_dat_i = $urandom;
            if (s_stb_o) begin
                int k;
                k = stbs; stbs++;
                if (s_cyc_o !== 1'b1 || s_we_o !== we || s_sel_o !== sel ||
                    s_adr_o !== adr || s_dat_o !== dat) bad++;
                if (k == lat) begin s_ack_i = 1'b1; s_dat_i = rdata; end
                if (drop >= 0 && k >= drop) mprj_wb_iena = 1'b0;
                if (abort >= 0 && k >= abort) begin m_cyc_i = 1'b0; m_stb_i = 1'b0; end
                if (clr_last && k == T - 1) timeout_clr = 1'b1;
            end else if (s_cyc_o) bad++;
            if (m_ack_o) begin
                acks++; rd = m_dat_o;
                if (ack_at < 0) ack_at = c;
                m_cyc_i = 1'b0; m_stb_i = 1'b0;
            end
        end
        mprj_wb_iena = 1'b1;
    endtask

    task automatic check_txn(input string tag, input int acks, input logic [31:0] rd,
                             input int stbs, input int ack_at, input int bad,
                             input int e_acks, input logic [31:0] e_rd, input int e_stbs);
        chk({tag, " ack_count"}, acks, e_acks);
        chk({tag, " stb_cycles"}, stbs, e_stbs);
        chk({tag, " slave_fields"}, bad, 0);
        if (e_acks == 1) begin
            chk({tag, " rdata"}, rd, e_rd);
            chk({tag, " ack_latency"}, ack_at, e_stbs);
        end
        chk({tag, " timeout_flag"}, timeout_flag, STAT ? exp_flag : 1'b0);
        chk({tag, " timeout_cnt"}, timeout_cnt, STAT ? exp_cnt : 0);
    endtask

    vec_t vecs[10];

    initial begin
        int acks, stbs, ack_at, bad, e_acks, e_stbs;
        logic [31:0] rd, e_rd;
        logic e_to;

        vecs[0] = '{1, 0, 4'hF, 32'h3000_0004, 32'h0, 32'h1234_5678, 0, -1, -1, 1, 32'h1234_5678, 1, 0};
        vecs[1] = '{1, 1, 4'b0011, 32'h3000_0010, 32'hA5A5_0000, 32'h0000_0042, 4, -1, -1, 1, 32'h0000_0042, 5, 0};
        vecs[2] = '{1, 0, 4'hF, 32'h3000_0020, 32'h0, 32'h1111_1111, -1, -1, -1, 1, ERR, 8, 1};
        vecs[3] = '{1, 0, 4'hF, 32'h3000_0024, 32'h0, 32'hCAFE_F00D, 7, -1, -1, 1, 32'hCAFE_F00D, 8, 0};
        vecs[4] = '{0, 1, 4'hF, 32'h3000_0028, 32'h5555_AAAA, 32'h7777_7777, 0, -1, -1, 1, 32'h0, 0, 0};
        vecs[5] = '{1, 0, 4'hF, 32'h3000_002C, 32'h0, 32'h2222_2222, -1, 2, -1, 1, 32'h0, 3, 0};
        vecs[6] = '{1, 1, 4'b1000, 32'h3000_0030, 32'h0102_0304, 32'h3333_3333, -1, -1, 3, 0, 32'h0, 4, 0};
        vecs[7] = '{1, 0, 4'hF, 32'h3000_0034, 32'h0, 32'h4444_4444, 0, -1, 0, 0, 32'h0, 1, 0};
        vecs[8] = '{1, 0, 4'hF, 32'h3000_0038, 32'h0, 32'h6666_6666, 3, 3, -1, 1, 32'h6666_6666, 4, 0};
        vecs[9] = '{1, 0, 4'hF, 32'h3000_003C, 32'h0, 32'h8888_8888, -1, 7, -1, 1, 32'h0, 8, 0};

        core_rstn = 1'b0; mprj_wb_iena = 1'b1; m_cyc_i = 1'b0; m_stb_i = 1'b0; m_we_i = 1'b0;
        m_sel_i = '0; m_adr_i = '0; m_dat_i = '0; s_ack_i = 1'b0; s_dat_i = '0; timeout_clr = 1'b0;
        repeat (2) @(negedge core_clk);
        chk("reset m_ack_o", m_ack_o, 0);
        chk("reset m_dat_o", m_dat_o, 0);
        chk("reset s_stb_cyc", {s_cyc_o, s_stb_o, s_we_o}, 0);
        chk("reset s_adr_sel", {s_adr_o, s_sel_o} == '0, 1);
        chk("reset status", {timeout_flag, timeout_cnt}, 0);
        core_rstn = 1'b1;

        for (int i = 0; i < 10; i++) begin
            run_txn(vecs[i].iena0, vecs[i].we, vecs[i].sel, vecs[i].adr, vecs[i].dat, vecs[i].rdata,
                    vecs[i].lat, vecs[i].drop, vecs[i].abort, 1'b0, acks, rd, stbs, ack_at, bad);
            status_update(vecs[i].exp_to, 1'b0);
            check_txn($sformatf("vec%0d", i), acks, rd, stbs, ack_at, bad,
                      vecs[i].exp_acks, vecs[i].exp_rd, vecs[i].exp_stbs);
        end

        // Clear coincident with a timeout: set wins, count restarts at 1
        run_txn(1, 0, 4'hF, 32'h3000_0040, 0, 0, -1, -1, -1, 1'b1, acks, rd, stbs, ack_at, bad);
        status_update(1'b1, 1'b1);
        check_txn("clr_collide", acks, rd, stbs, ack_at, bad, 1, ERR, T);

        @(negedge core_clk); timeout_clr = 1'b1;
        @(negedge core_clk); timeout_clr = 1'b0;
        exp_flag = 1'b0; exp_cnt = 0;
        chk("clr flag", timeout_flag, 1'b0);
        chk("clr cnt", timeout_cnt, 0);

        for (int i = 0; i < 300; i++) begin
            run_txn(1, 0, 4'hF, 32'h3000_0100, 0, 0, -1, -1, -1, 1'b0, acks, rd, stbs, ack_at, bad);
            status_update(1'b1, 1'b0);
        end
        check_txn("saturate", acks, rd, stbs, ack_at, bad, 1, ERR, T);

        for (int i = 0; i < 150; i++) begin
            logic iena0, we;
            logic [31:0] adr, dat, rdata;
            logic [3:0] sel;
            int lat, drop, abort;
            iena0 = ($urandom_range(0, 9) != 0);
            we = $urandom_range(0, 1);
            sel = $urandom; adr = $urandom; dat = $urandom; rdata = $urandom;
            lat   = int'($urandom_range(0, 10)) - 1;
            drop  = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 9)) : -1;
            abort = ($urandom_range(0, 4) == 0) ? int'($urandom_range(0, 9)) : -1;
            model(iena0, lat, drop, abort, rdata, e_acks, e_rd, e_stbs, e_to);
            run_txn(iena0, we, sel, adr, dat, rdata, lat, drop, abort, 1'b0,
                    acks, rd, stbs, ack_at, bad);
            status_update(e_to, 1'b0);
            check_txn($sformatf("rand%0d", i), acks, rd, stbs, ack_at, bad, e_acks, e_rd, e_stbs);
        end

        // Reset in the middle of a forwarded request
        @(negedge core_clk);
        mprj_wb_iena = 1'b1; m_cyc_i = 1'b1; m_stb_i = 1'b1; m_we_i = 1'b1;
        m_sel_i = 4'hF; m_adr_i = 32'h3000_0200; m_dat_i = 32'h1357_9BDF;
        repeat (3) @(negedge core_clk);
        chk("pre_reset s_stb_o", s_stb_o, 1'b1);
        core_rstn = 1'b0;
        #1;
        chk("async_reset s_cyc_stb", {s_cyc_o, s_stb_o}, 0);
        chk("async_reset m_ack_dat", {m_ack_o, m_dat_o}, 0);
        chk("async_reset s_fields", {s_we_o, s_sel_o, s_adr_o, s_dat_o} == '0, 1);
        chk("async_reset status", {timeout_flag, timeout_cnt}, 0);
        exp_flag = 1'b0; exp_cnt = 0;
        m_cyc_i = 1'b0; m_stb_i = 1'b0;
        @(negedge core_clk); core_rstn = 1'b1;
        repeat (2) @(negedge core_clk);
        chk("post_reset idle", {s_stb_o, m_ack_o}, 0);
        run_txn(1, 0, 4'hF, 32'h3000_0004, 0, 32'h1234_5678, 0, -1, -1, 1'b0, acks, rd, stbs, ack_at, bad);
        check_txn("post_reset txn", acks, rd, stbs, ack_at, bad, 1, 32'h1234_5678, 1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1);
    end
endmodule

// File: doc/mprj_wb_guard.md
# mprj_wb_guard

Wishbone guard stage between the management core's exported user-project bus (mprj_* master signals) and the user project area. It registers each request, forwards it to the user project slave, and returns the slave's response. It enforces a bounded response time: a missing ack becomes a single-cycle error response. This keeps a hung or unpowered user project from stalling the CPU.

## Interface
- TIMEOUT_CYCLES, 255: maximum cycles a forwarded request may wait for s_ack_i; legal range 1..65535.
- ERR_DATA, 32'hDEAD_BEEF: read data returned on timeout.

Ports:
- core_clk  in  1  the single clock.
- core_rstn  in  1  reset; asynchronous, active-low.
- mprj_wb_iena  in  1  user bus enable from the core; 0 means the user project is isolated.
- m_cyc_i  in  1  master cycle.
- m_stb_i  in  1  master strobe.
- m_we_i  in  1  master write enable.
- m_sel_i  in  4  master byte selects.
- m_adr_i  in  32  master address.
- m_dat_i  in  32  master write data.
- m_ack_o  out  1  ack to master; single-cycle pulse.
- m_dat_o  out  32  read data to master.
- s_cyc_o, s_stb_o, s_we_o  out  1 each  slave cycle, strobe and write enable.
- s_sel_o  out  4  slave byte selects.
- s_adr_o  out  32  slave address.
- s_dat_o  out  32  slave write data.
- s_ack_i  in  1  slave ack.
- s_dat_i  in  32  slave read data.
- timeout_clr  in  1  clears status; used only with the status macro.
- timeout_flag  out  1  sticky timeout indicator.
- timeout_cnt  out  8  count of timeouts.

## Operation
- FSM states: IDLE, REQ, ACK.
- **IDLE, m_cyc_i & m_stb_i & mprj_wb_iena:**
  - Latch we, sel, adr and dat into the s_* registers.
  - Clear the wait counter.
  - Go to REQ.
- **IDLE, m_cyc_i & m_stb_i & !mprj_wb_iena:**
  - Do not forward the request.
  - Load m_dat_o = 0.
  - Go to ACK.
- **REQ:**
  - s_cyc_o = s_stb_o = 1.
  - The wait counter increments each cycle. Counter width is $clog2(TIMEOUT_CYCLES+1).
  - s_ack_i=1: capture s_dat_i into m_dat_o (captured for writes too) and go to ACK.
  - Otherwise, if the counter reaches TIMEOUT_CYCLES-1: drop the slave, load m_dat_o=ERR_DATA, pulse the timeout event, go to ACK.
  - mprj_wb_iena falls: drop the slave, load m_dat_o=0, go to ACK.
  - m_cyc_i falls (master abort): drop the slave, go to IDLE, no m_ack_o.
- **Priority in REQ:** abort > s_ack_i > iena drop > timeout. s_ack_i on the final timeout cycle is a normal ack.
- **ACK:**
  - m_ack_o=1 for exactly one cycle.
  - s_cyc_o = s_stb_o = 0.
  - Go to IDLE next cycle.
  - IDLE does not re-accept in the cycle immediately after ACK; the master must deassert stb (classic Wishbone).
- m_dat_o holds its value until the next load.
- **Reset values:** all outputs 0, state IDLE, counter 0, timeout_flag 0, timeout_cnt 0. Reset mid-REQ drops s_cyc_o/s_stb_o immediately (asynchronously) and sends no ack.

## Timing
- Forwarding latency: m_stb_i sampled high at edge N, s_stb_o high after edge N.
- Response latency: s_ack_i sampled at edge M, m_ack_o high for the cycle after edge M.
- Minimum stb-to-ack round trip is 2 cycles, when the slave acks in the first REQ cycle.
- Timeout: s_stb_o is high for exactly TIMEOUT_CYCLES cycles, then m_ack_o pulses in the next cycle.
- Isolated (iena=0) request: m_ack_o pulses in the cycle after acceptance.

## Configuration
- MPRJ_WB_GUARD_STATUS_EN defined:
  - timeout_flag sets on each timeout event and stays set until timeout_clr=1.
  - timeout_cnt increments per timeout and saturates at 255.
  - timeout_clr clears both. If clear and a timeout event occur in the same cycle, set wins and timeout_cnt=1.
- Not defined: timeout_flag and timeout_cnt are tied to 0, timeout_clr is ignored, and no status registers are built.

## Test plan
- **Read, immediate ack:** read adr 0x3000_0004, slave acks in the first REQ cycle with 0x1234_5678 → m_ack_o after 2 cycles, m_dat_o=0x1234_5678, exactly one ack pulse.
- **Write passthrough:** write sel=4'b0011, dat 0xA5A5_0000, slave acks after 5 cycles → s_* fields match the master request, s_stb_o high for 5 cycles, one m_ack_o.
- **Timeout (TIMEOUT_CYCLES=8, slave never acks):**
  - s_stb_o high for 8 cycles, then m_ack_o with m_dat_o=0xDEAD_BEEF.
  - With the macro: timeout_flag=1, timeout_cnt=1. After 300 more timeouts, timeout_cnt=255.
  - Without the macro: timeout_flag=0, timeout_cnt=0.
- **Edge cases at the timeout boundary:**
  - s_ack_i on the 8th REQ cycle → normal ack with slave data, no flag.
  - timeout_clr together with a timeout event → flag stays 1, timeout_cnt=1.
- **Isolation:**
  - mprj_wb_iena=0 → s_cyc_o never rises; ack 1 cycle after acceptance with data 0.
  - iena dropped mid-REQ → slave released next cycle; ack with data 0.
- **Abort and reset:**
  - m_cyc_i dropped in REQ → no m_ack_o; s_cyc_o low next cycle.
  - core_rstn low mid-REQ → all outputs 0 immediately; FSM in IDLE after release.
